safety_light_sequencer: RTL and testbench

Parametrised next-generation lighting and horn front end for the Project Forward safety systems. It debounces the handlebar buttons and runs a blinker state machine with toggle, hazard and auto-cancel modes. It also generates a glitch-free brake/tail-light PWM and a debounced horn enable for the horn/DAC ramp block.

---
 rtl/safety_pkg.sv | 49 ++++
 rtl/debounce_filter.sv | 64 ++++++
 rtl/safety_light_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_safety_light_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/safety_pkg.sv
// Shared types, default 50 MHz timing constants and the blinker next-state
// function for the Project Forward lighting front end.
package safety_pkg;

    // Blinker operating mode; encodings are visible on the blinkMode port.
    typedef enum logic [1:0] {
        BLINK_OFF    = 2'd0,
        BLINK_LEFT   = 2'd1,
        BLINK_RIGHT  = 2'd2,
        BLINK_HAZARD = 2'd3
    } blink_mode_t;

    // One-cycle press events from the debounced blinker/hazard buttons.
    typedef struct packed {
        logic left;
        logic right;
        logic hazard;
    } press_t;

    // Default timing for a 50 MHz clock.
    localparam int DB_CYCLES_50M   = 500_000;     // 10 ms debounce
    localparam int HALF_PERIOD_50M = 12_500_000;  // 2 Hz blink
    localparam int AUTO_CANCEL_DEF = 10;          // full blink periods
    localparam int PWM_BITS_DEF    = 8;
    localparam int BRAKE_DUTY_DEF  = 255;
    localparam int TAIL_DUTY_DEF   = 64;

    // Mode after applying this cycle's press events. Hazard wins over any
    // simultaneous left/right; left+right together always request hazard;
    // in hazard a lone left or right press is ignored.
    function automatic blink_mode_t next_mode(input blink_mode_t cur,
                                              input press_t      p);
        blink_mode_t nxt;
        nxt = cur;
        if (p.hazard) begin
            nxt = (cur == BLINK_HAZARD) ? BLINK_OFF : BLINK_HAZARD;
        end else if (p.left && p.right) begin
            nxt = BLINK_HAZARD;
        end else if (cur != BLINK_HAZARD) begin
            if (p.left) begin
                nxt = (cur == BLINK_LEFT) ? BLINK_OFF : BLINK_LEFT;
            end else if (p.right) begin
                nxt = (cur == BLINK_RIGHT) ? BLINK_OFF : BLINK_RIGHT;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Button debouncer: 2-FF synchroniser followed by a stability counter.
// The debounced level flips only after the synchronised input has differed
// from it for DB_CYCLES consecutive cycles; rise pulses for one cycle when
// the debounced level goes high.
module debounce_filter
    import safety_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_50M
) (
    input  logic c50M,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    // Bring the asynchronous button into the clock domain.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours (sync2 gets old sync1).
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreement cycles and flip the level when stable.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rise_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= ~level_q;
                    rise_q  <= ~level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign dout = level_q;
    assign rise = rise_q;

endmodule

// File: rtl/safety_light_sequencer.sv
// Lighting and horn front end: debounced buttons, blinker FSM with
// toggle/hazard/auto-cancel, blink phase generator and brake/tail PWM.
module safety_light_sequencer
    import safety_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50M,
    parameter int HALF_PERIOD = HALF_PERIOD_50M,
    parameter int AUTO_CANCEL = AUTO_CANCEL_DEF,
    parameter int PWM_BITS    = PWM_BITS_DEF,
    parameter int BRAKE_DUTY  = BRAKE_DUTY_DEF,
    parameter int TAIL_DUTY   = TAIL_DUTY_DEF
) (
    input  logic       c50M,
    input  logic       reset,
    input  logic       leftBlinker,
    input  logic       rightBlinker,
    input  logic       hazard,
    input  logic       headLight,
    input  logic       horn,
    input  logic       brakes,
    output logic       leftBlinkerOut,
    output logic       rightBlinkerOut,
    output logic       headLightOut,
    output logic       brakeLightOut,
    output logic       hornActive,
    output logic [1:0] blinkMode
);

    localparam int            PH_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam int            PC_W    = (AUTO_CANCEL > 1) ? $clog2(AUTO_CANCEL) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'((AUTO_CANCEL > 0) ? AUTO_CANCEL - 1 : 0);
    localparam logic [PWM_BITS-1:0] BRAKE_D = PWM_BITS'(BRAKE_DUTY);
    localparam logic [PWM_BITS-1:0] TAIL_D  = PWM_BITS'(TAIL_DUTY);

    // ------------------------------------------------------------------
    // Button debouncers
    // ------------------------------------------------------------------
    logic left_level, right_level, hazard_level;
    logic left_rise, right_rise, hazard_rise;
    logic head_level, head_rise;
    logic horn_level, horn_rise;

    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_left (
        .c50M(c50M), .reset(reset), .din(leftBlinker),
        .dout(left_level), .rise(left_rise)
    );
    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_right (
        .c50M(c50M), .reset(reset), .din(rightBlinker),
        .dout(right_level), .rise(right_rise)
    );
    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_hazard (
        .c50M(c50M), .reset(reset), .din(hazard),
        .dout(hazard_level), .rise(hazard_rise)
    );
    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_head (
        .c50M(c50M), .reset(reset), .din(headLight),
        .dout(head_level), .rise(head_rise)
    );
    debounce_filter #(.DB_CYCLES(DB_CYCLES)) u_db_horn (
        .c50M(c50M), .reset(reset), .din(horn),
        .dout(horn_level), .rise(horn_rise)
    );

    // Blinker levels and level-input edges have no consumer here.
    logic unused_levels;
    assign unused_levels = &{1'b0, left_level, right_level, hazard_level,
                             head_rise, horn_rise};

    assign headLightOut = head_level;
    assign hornActive   = horn_level;

    // ------------------------------------------------------------------
    // Blinker FSM, phase generator and auto-cancel
    // ------------------------------------------------------------------
    blink_mode_t     mode_q, mode_d;
    logic            phase_q, phase_d;
    logic [PH_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [PC_W-1:0] period_q, period_d;
    logic            left_lamp_q, left_lamp_d;
    logic            right_lamp_q, right_lamp_d;
    press_t          press;
    logic            half_done;
    logic            steer_mode;
    logic            cancel;

    assign press      = '{left: left_rise, right: right_rise, hazard: hazard_rise};
    assign half_done  = (phase_cnt_q == PH_LAST);
    assign steer_mode = (mode_q == BLINK_LEFT) || (mode_q == BLINK_RIGHT);
    // The AUTO_CANCEL-th period ends when the OFF half of it completes.
    assign cancel     = (AUTO_CANCEL != 0) && steer_mode && !phase_q &&
                        half_done && (period_q == PC_LAST);

    // Next mode, phase and lamp values; a press always beats auto-cancel.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        mode_d      = next_mode(mode_q, press);
        phase_d     = phase_q;
        phase_cnt_d = phase_cnt_q + 1'b1;
        period_d    = period_q;

        if (!(|press) && cancel) begin
            mode_d = BLINK_OFF;
        end

        if (mode_d == BLINK_OFF) begin
            phase_d     = 1'b0;
            phase_cnt_d = '0;
            period_d    = '0;
        end else if (mode_d != mode_q) begin
            // Every entry into a blinking mode restarts with the lamp lit.
            phase_d     = 1'b1;
            phase_cnt_d = '0;
            period_d    = '0;
        end else if (half_done) begin
            phase_d     = ~phase_q;
            phase_cnt_d = '0;
            if ((AUTO_CANCEL != 0) && steer_mode && !phase_q) begin
                period_d = period_q + 1'b1;
            end
        end

        left_lamp_d  = phase_d && ((mode_d == BLINK_LEFT)  || (mode_d == BLINK_HAZARD));
        right_lamp_d = phase_d && ((mode_d == BLINK_RIGHT) || (mode_d == BLINK_HAZARD));
    end

    // Mode register with phase state and registered lamp drives.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            mode_q       <= BLINK_OFF;
            phase_q      <= 1'b0;
            phase_cnt_q  <= '0;
            period_q     <= '0;
            left_lamp_q  <= 1'b0;
            right_lamp_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            phase_cnt_q  <= phase_cnt_d;
            period_q     <= period_d;
            left_lamp_q  <= left_lamp_d;
            right_lamp_q <= right_lamp_d;
        end
    end

    assign leftBlinkerOut  = left_lamp_q;
    assign rightBlinkerOut = right_lamp_q;
    assign blinkMode       = mode_q;

    // ------------------------------------------------------------------
    // Brake / tail PWM
    // ------------------------------------------------------------------
    logic                brk_sync1_q, brk_sync2_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] target_duty;
    logic [PWM_BITS-1:0] duty_now;
    logic                brake_q;

    // Brake switch is already clean; only synchronise it.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            brk_sync1_q <= 1'b0;
            brk_sync2_q <= 1'b0;
        end else begin
            brk_sync1_q <= brakes;
            brk_sync2_q <= brk_sync1_q;
        end
    end

    // Duty priority, and the duty in force for the current count: a new
    // duty takes effect only at count 0 so no period is ever cut short.
    always_comb begin
        target_duty = '0;
        if (brk_sync2_q) begin
            target_duty = BRAKE_D;
        end else if (head_level) begin
            target_duty = TAIL_D;
        end
        duty_now = (pwm_cnt_q == '0) ? target_duty : duty_q;
    end

    // Free-running counter, period-aligned duty latch and registered output.
    always_ff @(posedge c50M or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            brake_q   <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            if (pwm_cnt_q == '0) begin
                duty_q <= target_duty;
            end
            brake_q <= (pwm_cnt_q < duty_now);
        end
    end

    assign brakeLightOut = brake_q;

endmodule

// File: tb/tb_safety_light_sequencer.sv
// Directed self-checking bench for safety_light_sequencer using small
// timing parameters: debounce 4, half period 8, auto-cancel 2, 4-bit PWM.
module tb_safety_light_sequencer;

    logic       c50M = 1'b0;
    logic       reset;
    logic       leftBlinker, rightBlinker, hazard, headLight, horn, brakes;
    logic       leftBlinkerOut, rightBlinkerOut, headLightOut;
    logic       brakeLightOut, hornActive;
    logic [1:0] blinkMode;

    int checks   = 0;
    int failures = 0;

    always #5 c50M = ~c50M;

    safety_light_sequencer #(
        .DB_CYCLES  (4),
        .HALF_PERIOD(8),
        .AUTO_CANCEL(2),
        .PWM_BITS   (4),
        .BRAKE_DUTY (15),
        .TAIL_DUTY  (4)
    ) dut (
        .c50M           (c50M),
        .reset          (reset),
        .leftBlinker    (leftBlinker),
        .rightBlinker   (rightBlinker),
        .hazard         (hazard),
        .headLight      (headLight),
        .horn           (horn),
        .brakes         (brakes),
        .leftBlinkerOut (leftBlinkerOut),
        .rightBlinkerOut(rightBlinkerOut),
        .headLightOut   (headLightOut),
        .brakeLightOut  (brakeLightOut),
        .hornActive     (hornActive),
        .blinkMode      (blinkMode)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; samples are taken on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge c50M);
    endtask

    // Wait (bounded) for brakeLightOut to go 0 -> 1.
    task automatic wait_brake_rise(output logic found);
        logic prev;
        prev  = brakeLightOut;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge c50M);
            if (!prev && brakeLightOut) begin
                found = 1'b1;
                break;
            end
            prev = brakeLightOut;
        end
    endtask

    logic rise_found;

    initial begin
        reset        = 1'b1;
        leftBlinker  = 1'b0;
        rightBlinker = 1'b0;
        hazard       = 1'b0;
        headLight    = 1'b0;
        horn         = 1'b0;
        brakes       = 1'b0;

        // Reset state
        tick(2);
        check("rst_mode",  blinkMode,       0);
        check("rst_left",  leftBlinkerOut,  0);
        check("rst_right", rightBlinkerOut, 0);
        check("rst_head",  headLightOut,    0);
        check("rst_brake", brakeLightOut,   0);
        check("rst_horn",  hornActive,      0);
        reset = 1'b0;
        tick(2);

        // 1. Short pulse ignored, then a held press enters LEFT on edge 7
        leftBlinker = 1'b1;
        tick(3);
        leftBlinker = 1'b0;
        tick(10);
        check("t1_glitch_mode", blinkMode,      0);
        check("t1_glitch_lamp", leftBlinkerOut, 0);

        leftBlinker = 1'b1;
        tick(6);
        check("t1_mode_pre", blinkMode, 0);
        tick(1);
        check("t1_mode_left", blinkMode, 1);

        // 2. Two full periods of 8 on / 8 off, then auto-cancel
        for (int i = 0; i < 32; i++) begin
            check("t2_left_lamp",  leftBlinkerOut,  ((i % 16) < 8) ? 1 : 0);
            check("t2_right_lamp", rightBlinkerOut, 0);
            if (i == 31) check("t2_mode_last", blinkMode, 1);
            if (i == 3) leftBlinker = 1'b0;
            tick(1);
        end
        check("t2_cancel_mode", blinkMode,      0);
        check("t2_cancel_lamp", leftBlinkerOut, 0);

        // 3. Simultaneous left+right -> hazard; left ignored; hazard -> off
        tick(4);
        leftBlinker  = 1'b1;
        rightBlinker = 1'b1;
        tick(7);
        check("t3_mode_hazard", blinkMode, 3);
        for (int i = 0; i < 16; i++) begin
            check("t3_haz_left",  leftBlinkerOut,  (i < 8) ? 1 : 0);
            check("t3_haz_right", rightBlinkerOut, (i < 8) ? 1 : 0);
            if (i == 2) begin
                leftBlinker  = 1'b0;
                rightBlinker = 1'b0;
            end
            tick(1);
        end
        leftBlinker = 1'b1;
        tick(7);
        check("t3_left_ignored", blinkMode, 3);
        leftBlinker = 1'b0;
        hazard      = 1'b1;
        tick(6);
        check("t3_haz_pre", blinkMode, 3);
        tick(1);
        check("t3_haz_off",   blinkMode,       0);
        check("t3_off_left",  leftBlinkerOut,  0);
        check("t3_off_right", rightBlinkerOut, 0);
        hazard = 1'b0;

        // 4. Right press in the middle of a LEFT on-phase
        tick(8);
        leftBlinker = 1'b1;
        tick(3);
        rightBlinker = 1'b1;
        tick(3);
        check("t4_mode_pre", blinkMode, 0);
        tick(1);
        check("t4_mode_left", blinkMode,      1);
        check("t4_left_on",   leftBlinkerOut, 1);
        leftBlinker = 1'b0;
        tick(2);
        check("t4_left_mid", leftBlinkerOut, 1);
        tick(1);
        check("t4_mode_right", blinkMode,       2);
        check("t4_left_off",   leftBlinkerOut,  0);
        check("t4_right_on",   rightBlinkerOut, 1);
        rightBlinker = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("t4_right_phase", rightBlinkerOut, (i < 8) ? 1 : 0);
            check("t4_left_quiet",  leftBlinkerOut,  0);
        end
        rightBlinker = 1'b1;
        tick(7);
        check("t4_right_toggle_off", blinkMode, 0);
        rightBlinker = 1'b0;

        // 5. Tail light 4/16, brakes mid-period -> 15/16 from next wrap
        headLight = 1'b1;
        horn      = 1'b1;
        tick(5);
        check("t5_head_pre", headLightOut, 0);
        check("t5_horn_pre", hornActive,   0);
        tick(1);
        check("t5_head_on", headLightOut, 1);
        check("t5_horn_on", hornActive,   1);
        wait_brake_rise(rise_found);
        check("t5_pwm_rise_found", rise_found, 1);
        for (int i = 0; i < 32; i++) begin
            check("t5_pwm", brakeLightOut,
                  (i < 16) ? ((i < 4) ? 1 : 0) : ((i < 31) ? 1 : 0));
            if (i == 6) brakes = 1'b1;
            tick(1);
        end

        // 6. Asynchronous reset mid-blink and mid-PWM, then left held
        leftBlinker = 1'b1;
        tick(7);
        check("t6_pre_mode", blinkMode,      1);
        check("t6_pre_lamp", leftBlinkerOut, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_mode",  blinkMode,       0);
        check("t6_rst_left",  leftBlinkerOut,  0);
        check("t6_rst_right", rightBlinkerOut, 0);
        check("t6_rst_head",  headLightOut,    0);
        check("t6_rst_brake", brakeLightOut,   0);
        check("t6_rst_horn",  hornActive,      0);
        tick(2);
        reset = 1'b0;
        tick(6);
        check("t6_mode_pre",  blinkMode,    0);
        check("t6_head_back", headLightOut, 1);
        tick(1);
        check("t6_mode_left", blinkMode,      1);
        check("t6_lamp_left", leftBlinkerOut, 1);
        leftBlinker = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
